instruction_queue: RTL

In-order instruction queue that sits between the instruction register and the Tomasulo dispatch stage. It is the IQ_SIG end of the IQ_2_IR interface: it accepts decoded control words and their RVFI shadow words from the instruction register and acknowledges each accepted word. It advertises free space to the instruction register and presents the oldest entry to dispatch with a valid/ready handshake. A flush input discards all entries on mispredict or exception.

---
 rtl/instruction_queue_if.sv | 43 ++++
 rtl/instruction_queue.sv | 82 ++++++++
 2 files changed

// File: rtl/instruction_queue_if.sv
// Shared instruction word types and the instruction-register <-> instruction-queue link.
// The queue implements the IQ_SIG end; the instruction register drives the IR_SIG end.
package tomasula_types;
    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } ctl_word;
endpackage

package rv32i_types;
    typedef struct packed {
        logic [63:0] order;
        logic [31:0] pc;
        logic [31:0] inst;
    } rvfi_word;
endpackage

interface IQ_2_IR;
    tomasula_types::ctl_word control_word;
    rv32i_types::rvfi_word   rvfi;
    logic                    ld_iq;
    logic                    issue_q_full_n;
    logic                    ack_o;

    modport IQ_SIG (
        input  control_word,
        input  rvfi,
        input  ld_iq,
        output issue_q_full_n,
        output ack_o
    );

    modport IR_SIG (
        output control_word,
        output rvfi,
        output ld_iq,
        input  issue_q_full_n,
        input  ack_o
    );
endinterface

// File: rtl/instruction_queue.sv
// In-order circular instruction queue between the instruction register and dispatch.
// Flush and reset clear pointers and occupancy only; entry storage keeps stale data.
module instruction_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    IQ_2_IR.IQ_SIG                  ir,
    input  logic                    flush,
    output logic                    dq_valid,
    output tomasula_types::ctl_word dq_control_word,
    output rv32i_types::rvfi_word   dq_rvfi,
    input  logic                    dq_ready,
    output logic [PTR_W:0]          count
);

    typedef struct packed {
        tomasula_types::ctl_word cw;
        rv32i_types::rvfi_word   rvfi;
    } entry_t;

    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count_next;
    logic             full_n_q;
    logic             push;
    logic             pop;

    // A push is judged against the registered full flag, so a full queue
    // refuses new words even when dispatch drains one in the same cycle.
    assign push = ir.ld_iq & full_n_q & ~flush & rst_n;
    assign pop  = dq_valid & dq_ready & ~flush & rst_n;

    assign ir.ack_o          = push;
    assign ir.issue_q_full_n = full_n_q;
    assign dq_valid          = (count != '0);
    assign dq_control_word   = mem[head].cw;
    assign dq_rvfi           = mem[head].rvfi;

    always_comb begin
        count_next = count;
        if (flush)
            count_next = '0;
        else if (push && !pop)
            count_next = count + CNT_ONE;
        else if (pop && !push)
            count_next = count - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            full_n_q <= 1'b1;
        end else if (flush) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            full_n_q <= 1'b1;
        end else begin
            if (push)
                tail <= tail + PTR_ONE;
            if (pop)
                head <= head + PTR_ONE;
            count    <= count_next;
            full_n_q <= (count_next != DEPTH_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[tail] <= '{cw: ir.control_word, rvfi: ir.rvfi};
    end

endmodule
